// File: rtl/spi_cfg_pkg.sv
// spi_cfg_pkg: FSM states, frame field offsets and default widths shared by the SPI config slave
package spi_cfg_pkg;
   localparam int WORD_W_DEF   = 25;
   localparam int ADDR_W_DEF   = 4;
   localparam int DATA_W_DEF   = 16;
   localparam int NUM_REGS_DEF = 16;
   // field positions counted down from the frame MSB
   localparam int VALID_OFS = 1;
   localparam int RW_OFS    = 2;
   localparam int ADDR_OFS  = 2;
   typedef enum logic [2:0] {IDLE, CMD, TURN, READ, WBURST, DONE} state_t;
   function automatic int addr_lsb(input int word_w, input int addr_w);
      return word_w - ADDR_OFS - addr_w;
   endfunction
endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: MSB-first shift register and bit counter shared by frame capture and read-back
module spi_shift_reg import spi_cfg_pkg::*; #(
   parameter int WORD_W = WORD_W_DEF,
   parameter int CNT_W  = $clog2(WORD_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              shift,
   input  logic              load,
   input  logic              mosi,
   input  logic [WORD_W-1:0] load_val,
   output logic [WORD_W-1:0] sr,
   output logic [CNT_W-1:0]  cnt
);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr  <= '0;
         cnt <= '0;
      end else if (load) begin
         sr  <= load_val;
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (shift) begin
         sr  <= {sr[WORD_W-2:0], mosi};
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/spi_cfg_slave.sv
// spi_cfg_slave: SPI-framed debug access to a register file with read-only status and auto-increment bursts
module spi_cfg_slave import spi_cfg_pkg::*; #(
   parameter int                         WORD_W   = WORD_W_DEF,
   parameter int                         ADDR_W   = ADDR_W_DEF,
   parameter int                         DATA_W   = DATA_W_DEF,
   parameter int                         NUM_REGS = NUM_REGS_DEF,
   parameter logic [NUM_REGS-1:0]        RO_MASK  = '0,
   parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL  = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       debug,
   input  logic                       ss_n,
   input  logic                       mosi,
   output logic                       miso,
   input  logic [NUM_REGS*DATA_W-1:0] status_in,
   output logic [NUM_REGS*DATA_W-1:0] cfg_out,
   output logic [NUM_REGS-1:0]        wr_strobe,
   output logic                       spi_data_ready,
   output logic                       frame_err,
   output logic                       addr_err
);
   localparam int                CNT_W     = $clog2(WORD_W);
   localparam int                VALID_BIT = WORD_W - VALID_OFS;
   localparam int                RW_BIT    = WORD_W - RW_OFS;
   localparam int                ADDR_LSB  = addr_lsb(WORD_W, ADDR_W);
   localparam logic [ADDR_W:0]   NREG      = NUM_REGS[ADDR_W:0];
   localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(NUM_REGS - 1);
   localparam logic [CNT_W-1:0]  WORD_END  = CNT_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0]  DATA_END  = CNT_W'(DATA_W - 1);

   state_t                     state, state_d;
   logic [WORD_W-1:0]          sr, word, load_val;
   logic [CNT_W-1:0]           cnt;
   logic [NUM_REGS*DATA_W-1:0] regs;
   logic [NUM_REGS-1:0]        strobe_d;
   logic [ADDR_W-1:0]          addr_q, addr_d, fa, wa, ra;
   logic [DATA_W-1:0]          rdata, wd;
   logic                       inc_q, inc_d, active, start;
   logic                       clr, shift, load, wreq, rreq, set_rdy, ferr, aerr;

   function automatic logic [ADDR_W-1:0] nxt(input logic [ADDR_W-1:0] a);
      return a == LAST ? '0 : a + 1'b1;
   endfunction

   spi_shift_reg #(.WORD_W(WORD_W), .CNT_W(CNT_W)) u_shift (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .shift    (shift),
      .load     (load),
      .mosi     (mosi),
      .load_val (load_val),
      .sr       (sr),
      .cnt      (cnt)
   );

   // word includes the bit arriving this cycle, so decode happens on the last-bit edge
   assign word     = {sr[WORD_W-2:0], mosi};
   assign fa       = ADDR_W'(word >> ADDR_LSB);
   assign wd       = DATA_W'(word);
   assign active   = !ss_n && debug;
   assign start    = state == IDLE && active;
   assign wa       = state == CMD ? fa : addr_q;
   assign ra       = state == READ ? nxt(addr_q) : addr_q;
   assign load_val = WORD_W'(rdata);
   assign aerr     = (wreq && strobe_d == '0) || (rreq && {1'b0, ra} >= NREG);
   assign miso     = state == READ && sr[WORD_W-1];
   assign cfg_out  = debug ? regs : RST_VAL;

   always_comb begin
      state_d = state;
      addr_d  = addr_q;
      inc_d   = inc_q;
      clr     = 1'b0;
      shift   = 1'b0;
      load    = 1'b0;
      wreq    = 1'b0;
      rreq    = 1'b0;
      set_rdy = 1'b0;
      ferr    = 1'b0;
      if (state == IDLE) begin
         shift   = active;
         clr     = !active;
         state_d = active ? CMD : IDLE;
      end else if (!active) begin
         clr     = 1'b1;
         ferr    = state == CMD || (state == WBURST && cnt != '0);
         state_d = IDLE;
      end else begin
         case (state)
            CMD: begin
               shift = 1'b1;
               if (cnt == WORD_END) begin
                  clr     = 1'b1;
                  set_rdy = 1'b1;
                  addr_d  = word[RW_BIT] ? fa : nxt(fa);
                  inc_d   = word[DATA_W];
                  wreq    = word[VALID_BIT] && !word[RW_BIT];
                  state_d = !word[VALID_BIT] ? DONE : word[RW_BIT] ? TURN : word[DATA_W] ? WBURST : DONE;
               end
            end
            TURN: begin
               load    = 1'b1;
               rreq    = 1'b1;
               state_d = READ;
            end
            READ: begin
               shift = 1'b1;
               if (cnt == WORD_END) begin
                  load    = inc_q;
                  rreq    = inc_q;
                  clr     = !inc_q;
                  addr_d  = inc_q ? ra : addr_q;
                  state_d = inc_q ? READ : DONE;
               end
            end
            WBURST: begin
               shift = 1'b1;
               if (cnt == DATA_END) begin
                  clr    = 1'b1;
                  wreq   = 1'b1;
                  addr_d = nxt(addr_q);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rdata    = '0;
      strobe_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (ra == ADDR_W'(i)) rdata = RO_MASK[i] ? status_in[i*DATA_W +: DATA_W] : regs[i*DATA_W +: DATA_W];
         strobe_d[i] = wreq && wa == ADDR_W'(i) && !RO_MASK[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         addr_q         <= '0;
         inc_q          <= 1'b0;
         regs           <= RST_VAL;
         wr_strobe      <= '0;
         spi_data_ready <= 1'b0;
         frame_err      <= 1'b0;
         addr_err       <= 1'b0;
      end else begin
         state          <= state_d;
         addr_q         <= addr_d;
         inc_q          <= inc_d;
         wr_strobe      <= strobe_d;
         spi_data_ready <= set_rdy || (spi_data_ready && !start);
         frame_err      <= ferr;
         addr_err       <= aerr;
         for (int i = 0; i < NUM_REGS; i++)
            if (strobe_d[i]) regs[i*DATA_W +: DATA_W] <= wd;
      end
   end
endmodule

// File: tb/tb_spi_cfg_slave.sv
// tb_spi_cfg_slave: directed table, corner sequences and random frames against a register-array model
module tb_spi_cfg_slave;
   localparam int WORD_W = 25, ADDR_W = 4, DATA_W = 16, NUM_REGS = 16;
   localparam int IMG_W = NUM_REGS * DATA_W;
   localparam logic [NUM_REGS-1:0] RO = 16'h1000;
   typedef logic [IMG_W-1:0] w_t;

   function automatic w_t mk_img(input logic [15:0] base);
      w_t v;
      for (int i = 0; i < NUM_REGS; i++) v[i*DATA_W +: DATA_W] = base + 16'(i);
      return v;
   endfunction
   localparam w_t RST = mk_img(16'hA000);

   logic clk = 1'b0, rst_n = 1'b0, debug = 1'b1, ss_n = 1'b1, mosi = 1'b0;
   logic miso, spi_data_ready, frame_err, addr_err;
   w_t status_in, cfg_out;
   logic [NUM_REGS-1:0] wr_strobe;
   logic [DATA_W-1:0] model [NUM_REGS];
   int n_chk = 0, n_fail = 0;

   spi_cfg_slave #(.RO_MASK(RO), .RST_VAL(RST)) dut (
      .clk(clk), .rst_n(rst_n), .debug(debug), .ss_n(ss_n), .mosi(mosi), .miso(miso),
      .status_in(status_in), .cfg_out(cfg_out), .wr_strobe(wr_strobe),
      .spi_data_ready(spi_data_ready), .frame_err(frame_err), .addr_err(addr_err));

   always #5 clk = ~clk;

   task automatic check(input string nm, input w_t got, input w_t exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic w_t img();
      w_t v;
      for (int i = 0; i < NUM_REGS; i++) v[i*DATA_W +: DATA_W] = model[i];
      return v;
   endfunction

   function automatic logic [DATA_W-1:0] exp_rd(input logic [3:0] a);
      return RO[a] ? status_in[int'(a)*DATA_W +: DATA_W] : model[a];
   endfunction

   function automatic logic [WORD_W-1:0] frm(input logic v, input logic rd, input logic [3:0] a,
                                             input logic inc, input logic [15:0] d);
      return {v, rd, a, 2'b00, inc, d};
   endfunction

   task automatic send_bits(input logic [WORD_W-1:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         ss_n = 1'b0;
         mosi = w[i];
         @(negedge clk);
      end
      mosi = 1'b0;
   endtask

   task automatic collect(input int n, output logic [2*WORD_W-1:0] b, output logic ae);
      b = '0;
      ae = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         b = {b[2*WORD_W-2:0], miso};
         ae = ae | addr_err;
      end
   endtask

   task automatic do_write(input string nm, input logic [3:0] a, input logic [15:0] d, input logic v,
                           input logic [15:0] es, input logic ea);
      send_bits(frm(v, 1'b0, a, 1'b0, d), WORD_W);
      check({nm, " strobe"}, w_t'(wr_strobe), w_t'(es));
      check({nm, " addr_err"}, w_t'(addr_err), w_t'(ea));
      check({nm, " ready"}, w_t'(spi_data_ready), w_t'(1));
      if (es != 16'h0) model[a] = d;
      ss_n = 1'b1;
      @(negedge clk);
      check({nm, " strobe pulse"}, w_t'(wr_strobe), w_t'(0));
      @(negedge clk);
      check({nm, " image"}, cfg_out, img());
   endtask

   task automatic do_read(input string nm, input logic [3:0] a, input logic [WORD_W-1:0] exp);
      logic [2*WORD_W-1:0] b;
      logic ae;
      send_bits(frm(1'b1, 1'b1, a, 1'b0, 16'h0), WORD_W);
      check({nm, " turn"}, w_t'(miso), w_t'(0));
      collect(WORD_W, b, ae);
      check({nm, " data"}, w_t'(b[WORD_W-1:0]), w_t'(exp));
      check({nm, " addr_err"}, w_t'(ae), w_t'(0));
      ss_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic rd; logic v; logic [3:0] a; logic [15:0] d;
      logic [15:0] es; logic ea; logic [WORD_W-1:0] er;
   } vec_t;
   vec_t tbl [12];

   initial begin
      logic [WORD_W-1:0] f;
      logic [2*WORD_W-1:0] b;
      logic ae, v;
      logic [3:0] a;
      logic [15:0] d;
      status_in = mk_img(16'h5000);
      status_in[12*DATA_W +: DATA_W] = 16'h30F0;
      for (int i = 0; i < NUM_REGS; i++) model[i] = RST[i*DATA_W +: DATA_W];
      tbl[0]  = '{1'b0, 1'b1, 4'd4,  16'hC3C1, 16'h0010, 1'b0, 25'h0};
      tbl[1]  = '{1'b1, 1'b1, 4'd4,  16'h0,    16'h0,    1'b0, 25'h00C3C1};
      tbl[2]  = '{1'b1, 1'b1, 4'd12, 16'h0,    16'h0,    1'b0, 25'h0030F0};
      tbl[3]  = '{1'b0, 1'b1, 4'd12, 16'h5555, 16'h0,    1'b1, 25'h0};
      tbl[4]  = '{1'b1, 1'b1, 4'd12, 16'h0,    16'h0,    1'b0, 25'h0030F0};
      tbl[5]  = '{1'b1, 1'b1, 4'd7,  16'h0,    16'h0,    1'b0, 25'h00A007};
      tbl[6]  = '{1'b0, 1'b0, 4'd5,  16'h1234, 16'h0,    1'b0, 25'h0};
      tbl[7]  = '{1'b1, 1'b1, 4'd5,  16'h0,    16'h0,    1'b0, 25'h00A005};
      tbl[8]  = '{1'b0, 1'b1, 4'd0,  16'hFFFF, 16'h0001, 1'b0, 25'h0};
      tbl[9]  = '{1'b1, 1'b1, 4'd0,  16'h0,    16'h0,    1'b0, 25'h00FFFF};
      tbl[10] = '{1'b0, 1'b1, 4'd15, 16'h8001, 16'h8000, 1'b0, 25'h0};
      tbl[11] = '{1'b1, 1'b1, 4'd15, 16'h0,    16'h0,    1'b0, 25'h008001};

      repeat (3) @(negedge clk);
      check("reset image", cfg_out, RST);
      check("reset outputs", w_t'({miso, wr_strobe, spi_data_ready, frame_err, addr_err}), w_t'(0));
      rst_n = 1'b1;
      @(negedge clk);

      foreach (tbl[i]) begin
         if (tbl[i].rd) do_read($sformatf("vec%0d", i), tbl[i].a, tbl[i].er);
         else do_write($sformatf("vec%0d", i), tbl[i].a, tbl[i].d, tbl[i].v, tbl[i].es, tbl[i].ea);
      end

      send_bits(frm(1'b1, 1'b0, 4'd14, 1'b1, 16'h1111), WORD_W);
      check("bw0 strobe", w_t'(wr_strobe), w_t'(16'h4000));
      send_bits(25'h2222, 16);
      check("bw1 strobe", w_t'(wr_strobe), w_t'(16'h8000));
      send_bits(25'h3333, 16);
      check("bw2 strobe", w_t'(wr_strobe), w_t'(16'h0001));
      model[14] = 16'h1111;
      model[15] = 16'h2222;
      model[0]  = 16'h3333;
      ss_n = 1'b1;
      @(negedge clk);
      check("bw end frame_err", w_t'(frame_err), w_t'(0));
      @(negedge clk);
      check("bw image", cfg_out, img());

      send_bits(frm(1'b1, 1'b1, 4'd15, 1'b1, 16'h0), WORD_W);
      check("br turn", w_t'(miso), w_t'(0));
      collect(2 * WORD_W, b, ae);
      check("br data", w_t'(b), w_t'({9'h0, model[15], 9'h0, model[0]}));
      ss_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("ready hold", w_t'(spi_data_ready), w_t'(1));

      f = frm(1'b1, 1'b0, 4'd3, 1'b0, 16'h7777);
      send_bits(f >> 24, 1);
      check("ready clear", w_t'(spi_data_ready), w_t'(0));
      send_bits(f >> 13, 11);
      ss_n = 1'b1;
      @(negedge clk);
      check("abort frame_err", w_t'(frame_err), w_t'(1));
      check("abort strobe", w_t'(wr_strobe), w_t'(0));
      @(negedge clk);
      check("abort frame_err pulse", w_t'(frame_err), w_t'(0));
      check("abort image", cfg_out, img());
      do_read("post abort", 4'd3, 25'(model[3]));

      debug = 1'b0;
      @(negedge clk);
      check("debug0 image", cfg_out, RST);
      debug = 1'b1;
      @(negedge clk);
      check("debug1 image", cfg_out, img());

      send_bits(frm(1'b1, 1'b0, 4'd2, 1'b0, 16'hBEEF) >> 15, 10);
      debug = 1'b0;
      @(negedge clk);
      check("debug drop frame_err", w_t'(frame_err), w_t'(1));
      check("debug drop strobe", w_t'(wr_strobe), w_t'(0));
      check("debug drop rst image", cfg_out, RST);
      ss_n = 1'b1;
      @(negedge clk);
      debug = 1'b1;
      @(negedge clk);
      check("debug drop image", cfg_out, img());

      for (int k = 0; k < 40; k++) begin
         a = 4'($urandom_range(0, 15));
         d = 16'($urandom);
         v = $urandom_range(0, 7) != 0;
         status_in[12*DATA_W +: DATA_W] = 16'($urandom);
         if ($urandom_range(0, 1) == 1) do_read($sformatf("rnd%0d rd", k), a, 25'(exp_rd(a)));
         else do_write($sformatf("rnd%0d wr", k), a, d, v,
                       (v && !RO[a]) ? (16'd1 << a) : 16'd0, v && RO[a]);
      end

      send_bits(frm(1'b1, 1'b1, 4'd4, 1'b0, 16'h0), WORD_W);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst in read miso", w_t'(miso), w_t'(0));
      check("rst in read image", cfg_out, RST);
      check("rst in read flags", w_t'({wr_strobe, spi_data_ready, frame_err, addr_err}), w_t'(0));
      rst_n = 1'b1;
      ss_n = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) model[i] = RST[i*DATA_W +: DATA_W];
      repeat (2) @(negedge clk);
      do_read("post reset", 4'd4, 25'h00A004);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_cfg_slave.md
SPI_CFG_SLAVE -- requirements
Module: spi_cfg_slave

Interface
REQ-001 SHALL provide parameters WORD_W (default 25), the SPI frame length in bits.
REQ-002 SHALL provide parameters ADDR_W (default 4), the register address width.
REQ-003 SHALL provide parameters DATA_W (default 16), the register data width.
REQ-004 SHALL provide parameters NUM_REGS (default 16), the number of implemented registers, with NUM_REGS <= 2**ADDR_W.
REQ-005 SHALL provide parameters RO_MASK (default 0), a NUM_REGS-bit mask; bit i set makes register i read-only status.
REQ-006 SHALL provide parameters RST_VAL (default 0), the NUM_REGS*DATA_W reset and default image.
REQ-007 Ports SHALL be exactly as follows; one clock, with synchronous, active-low reset:
- clk  in  1  system clock; mosi, ss_n and miso all sampled/driven on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- debug  in  1  debug enable; when 0, frames are ignored.
- ss_n  in  1  slave select, active low.
- mosi  in  1  serial data in, MSB first.
- miso  out  1  serial data out, MSB first.
- status_in  in  NUM_REGS*DATA_W  read-only register sources.
- cfg_out  out  NUM_REGS*DATA_W  register image.
- wr_strobe  out  NUM_REGS  one-cycle pulse per register written.
- spi_data_ready  out  1  frame-complete flag.
- frame_err  out  1  one-cycle pulse on an aborted frame.
- addr_err  out  1  one-cycle pulse on an out-of-range or read-only write.

Function
REQ-008 Frame layout SHALL be: bit WORD_W-1 = valid; bit WORD_W-2 = rd(1)/wr(0); next ADDR_W bits = address; then pad bits, of which the lowest is AUTO_INC; low DATA_W bits = data. WORD_W SHALL equal 2+ADDR_W+DATA_W+pad, with pad >= 1.
REQ-009 While ss_n=0 and debug=1, mosi SHALL be shifted in every clk; the bit counter SHALL start at the ss_n falling edge.
REQ-010 FSM states SHALL be IDLE, CMD, TURN, READ, WBURST, DONE.
- IDLE->CMD on ss_n=0 with debug=1.
- CMD->decode after WORD_W bits.
REQ-011 Write with valid=1: on the cycle after the last bit, the register SHALL update and wr_strobe[addr] SHALL pulse. Next state: WBURST if AUTO_INC, else DONE.
REQ-012 Read with valid=1: one TURN cycle (miso=0) SHALL follow. READ SHALL then drive WORD_W bits of zero-extended data, MSB first.
- Data source is status_in for RO_MASK registers, else the register value.
- After READ: with AUTO_INC and ss_n still low, the next address SHALL be read immediately with no extra turnaround; otherwise DONE.
REQ-013 In WBURST, each further DATA_W bits SHALL be written to address+1; this continues until ss_n=1.
REQ-014 Auto-increment SHALL wrap from NUM_REGS-1 to 0.
REQ-015 valid=0 frames SHALL be consumed with no register, miso or strobe effect; spi_data_ready SHALL still set.
REQ-016 Write to address >= NUM_REGS or to an RO_MASK register SHALL be dropped, with addr_err pulsing. Read of address >= NUM_REGS SHALL return 0 with addr_err pulsing.
REQ-017 spi_data_ready SHALL set on the decode cycle of each frame and hold until the next ss_n falling edge.
REQ-018 ss_n=1 before WORD_W bits in CMD (or mid-word in WBURST) SHALL pulse frame_err, make no write, and return to IDLE.
REQ-019 ss_n=1 in any state SHALL return the FSM to IDLE next cycle, and miso SHALL go 0.
REQ-020 debug=0 SHALL force cfg_out to RST_VAL while the internal registers retain their values. A frame in progress when debug falls SHALL abort as in REQ-018.
REQ-021 miso SHALL be 0 whenever the FSM is not in READ.

Reset
REQ-022 With rst_n=0 at a clk edge, the following SHALL hold next cycle, including mid-frame:
- registers = RST_VAL; FSM = IDLE; counters = 0.
- miso=0, wr_strobe=0, spi_data_ready=0, frame_err=0, addr_err=0.

Structure
REQ-023 Package spi_cfg_pkg SHALL hold the FSM state enum, frame field offset constants and the default widths.
REQ-024 One sub-module, spi_shift_reg, SHALL hold the WORD_W-bit shift-in/shift-out register and bit counter; spi_cfg_slave SHALL hold the FSM and the register file.

Verification
REQ-025 Defaults: write frame 1_0_0100_000_0xC3C1 -> next cycle cfg_out[4]=0xC3C1, wr_strobe[4] pulses, spi_data_ready=1.
REQ-026 Read frame 1_1_0100_000_0 -> after 1 TURN cycle, miso shifts 25 bits = 0x00C3C1.
REQ-027 RO_MASK[12]=1, status_in[12]=0x30F0: read address 12 -> 0x0030F0. Write address 12 -> addr_err pulses and cfg_out is unchanged.
REQ-028 Burst write at address 14 with AUTO_INC, then 3 data words 0x1111, 0x2222, 0x3333 -> registers 14, 15 and 0 updated (wrap).
REQ-029 ss_n raised after 12 bits -> frame_err pulses, no strobe, FSM IDLE. debug=0 -> cfg_out=RST_VAL; debug=1 -> prior values reappear.
REQ-030 rst_n=0 during READ -> miso=0 and all registers = RST_VAL on the next cycle.
